// File: rtl/lbp_gray_arbiter.sv
// Two-requester round-robin arbiter sharing the gray-image memory read port between two LBP engines.
// Optional per-requester beat and forced-switch counters are enabled by defining LBP_ARB_STATS_EN.
module lbp_gray_arbiter #(
  parameter int unsigned AW        = 14,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
`ifdef LBP_ARB_STATS_EN
  output logic [15:0]   stat0,
  output logic [15:0]   stat1,
  output logic [15:0]   stat_sw,
`endif
  output logic          busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [CW-1:0] bcnt_inc;
  logic          tag_q;
  logic          own_id, own_req, oth_req;
  logic [1:0]    oth_state;
  logic          acc0, acc1, acc_any;
  logic          limit_sw;

  assign m0_gnt  = (state_q == OWN0) & gray_ready;
  assign m1_gnt  = (state_q == OWN1) & gray_ready;
  assign acc0    = m0_req & m0_gnt;
  assign acc1    = m1_req & m1_gnt;
  assign acc_any = acc0 | acc1;

  assign own_id    = (state_q == OWN1);
  assign own_req   = own_id ? m1_req : m0_req;
  assign oth_req   = own_id ? m0_req : m1_req;
  assign oth_state = own_id ? OWN0 : OWN1;
  assign bcnt_inc  = bcnt_q + CW'(1);

  assign busy = (state_q != IDLE) | gray_req;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    bcnt_d   = bcnt_q;
    limit_sw = 1'b0;
    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (m0_req && m1_req) state_d = rr_q ? OWN1 : OWN0;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          rr_d    = ~own_id;
          bcnt_d  = '0;
          state_d = oth_req ? oth_state : IDLE;
        end else if (gray_ready) begin
          // The limit beat is still taken; ownership only moves if the other side waits.
          if (bcnt_inc == CW'(MAX_BURST)) begin
            bcnt_d = '0;
            if (oth_req) begin
              state_d  = oth_state;
              rr_d     = own_id;
              limit_sw = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Issue stage registers the address; return stage steers the following data by tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_req  <= 1'b0;
      gray_addr <= '0;
      tag_q     <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      gray_req <= acc_any;
      if (acc_any) begin
        gray_addr <= acc1 ? m1_addr : m0_addr;
        tag_q     <= acc1;
      end
      m0_rvalid <= gray_req & ~tag_q;
      m1_rvalid <= gray_req & tag_q;
      if (gray_req && !tag_q) m0_rdata <= gray_data;
      if (gray_req && tag_q)  m1_rdata <= gray_data;
    end
  end

`ifdef LBP_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat0   <= '0;
      stat1   <= '0;
      stat_sw <= '0;
    end else begin
      if (acc0 && stat0 != 16'hFFFF)       stat0   <= stat0 + 16'd1;
      if (acc1 && stat1 != 16'hFFFF)       stat1   <= stat1 + 16'd1;
      if (limit_sw && stat_sw != 16'hFFFF) stat_sw <= stat_sw + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lbp_gray_arbiter.sv
// Bench for lbp_gray_arbiter: directed bring-up, stall and reset steps, then randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_lbp_gray_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MAX_BURST = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          gray_ready, gray_req, busy;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
`ifdef LBP_ARB_STATS_EN
  logic [15:0]   stat0, stat1, stat_sw;
`endif

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = 8'(a * 7);
    return t ^ {2'b10, a[13:8]};
  endfunction

  // Memory emulation: data for the address currently presented.
  assign gray_data = mem_f(gray_addr);

  lbp_gray_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_addr    (m1_addr),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
`ifdef LBP_ARB_STATS_EN
    .stat0      (stat0),
    .stat1      (stat1),
    .stat_sw    (stat_sw),
`endif
    .busy       (busy)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: owner -1 means nobody owns the port.
  int            own, beats, rr, acc_who, e_tag;
  int            e_st[2];
  int            e_sw;
  bit            e_greq;
  logic [AW-1:0] e_gaddr;
  bit            e_rv[2];
  logic [DW-1:0] e_rd[2];
  logic [AW-1:0] addr[2];
  int            pb[2];
  int            mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    own = -1; beats = 0; rr = 0; acc_who = -1; e_tag = 0;
    e_greq = 0; e_gaddr = '0;
    e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
    e_st[0] = 0; e_st[1] = 0; e_sw = 0;
  endtask

  task automatic model_step();
    bit r[2];
    int o;
    r[0] = m0_req; r[1] = m1_req;
    e_rv[0] = 0; e_rv[1] = 0;
    if (e_greq) begin
      e_rv[e_tag] = 1;
      e_rd[e_tag] = mem_f(e_gaddr);
    end
    acc_who = -1;
    if (own < 0) begin
      beats = 0;
      if (r[0] && r[1]) own = rr;
      else if (r[0])    own = 0;
      else if (r[1])    own = 1;
    end else begin
      o = 1 - own;
      if (!r[own]) begin
        rr = o; beats = 0;
        own = r[o] ? o : -1;
      end else if (gray_ready) begin
        acc_who = own;
        beats++;
        if (beats == MAX_BURST) begin
          beats = 0;
          if (r[o]) begin
            rr = own; own = o;
            if (e_sw < 65535) e_sw++;
          end
        end
      end
    end
    if (acc_who >= 0) begin
      e_greq = 1; e_gaddr = addr[acc_who]; e_tag = acc_who;
      if (e_st[acc_who] < 65535) e_st[acc_who]++;
    end else begin
      e_greq = 0;
    end
  endtask

  task automatic check_all();
    chk("m0_gnt", 32'(m0_gnt), 32'((own == 0) && gray_ready));
    chk("m1_gnt", 32'(m1_gnt), 32'((own == 1) && gray_ready));
    chk("gray_req", 32'(gray_req), 32'(e_greq));
    chk("gray_addr", 32'(gray_addr), 32'(e_gaddr));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
    chk("m0_rdata", 32'(m0_rdata), 32'(e_rd[0]));
    chk("m1_rdata", 32'(m1_rdata), 32'(e_rd[1]));
    chk("busy", 32'(busy), 32'((own >= 0) || e_greq));
`ifdef LBP_ARB_STATS_EN
    chk("stat0", 32'(stat0), 32'(e_st[0]));
    chk("stat1", 32'(stat1), 32'(e_st[1]));
    chk("stat_sw", 32'(stat_sw), 32'(e_sw));
`endif
  endtask

  // mode 0: random traffic, 1: each requester takes 18 beats, 2: inputs held by the caller
  task automatic drive();
    if (acc_who >= 0) begin
      addr[acc_who] = addr[acc_who] + 14'd1;
      pb[acc_who]++;
    end
    if (mode == 0) begin
      m0_req     = ($urandom_range(0, 9) < 7);
      m1_req     = ($urandom_range(0, 9) < 7);
      gray_ready = ($urandom_range(0, 9) < 8);
    end else if (mode == 1) begin
      m0_req     = (pb[0] < 18);
      m1_req     = (pb[1] < 18);
      gray_ready = 1'b1;
    end
    m0_addr = addr[0];
    m1_addr = addr[1];
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
    drive();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;
    mode = 2;
    reset = 1'b0;
    m0_req = 1'b1; m1_req = 1'b0; gray_ready = 1'b1;
    addr[0] = 14'h0081; addr[1] = 14'h2000;
    m0_addr = addr[0]; m1_addr = addr[1];
    pb[0] = 0; pb[1] = 0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    reset = 1'b1;

    // Bring-up: grant one cycle after release, 0x0081 returns two cycles after acceptance.
    cycle();
    chk("gnt_after_release", 32'(m0_gnt), 32'd1);
    cycle();
    chk("issue_0x81_req", 32'(gray_req), 32'd1);
    chk("issue_0x81_addr", 32'(gray_addr), 32'h0081);
    chk("issue_0x81_no_rvalid", 32'(m0_rvalid), 32'd0);
    cycle();
    chk("ret_0x81_valid", 32'(m0_rvalid), 32'd1);
    chk("ret_0x81_data", 32'(m0_rdata), 32'(mem_f(14'h0081)));

    // Stall mid-burst.
    repeat (2) cycle();
    gray_ready = 1'b0;
    repeat (3) cycle();
    gray_ready = 1'b1;
    repeat (4) cycle();
    m0_req = 1'b0;
    repeat (3) cycle();

    // Reset one cycle after an accepted beat discards the in-flight return.
    m1_req = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (acc_who != 1 && n < 10);
    chk("midreset_beat_accepted", 32'(acc_who), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) cycle();
    @(negedge clk);
    reset = 1'b1;

    // Both requesters take 18 beats each from a fresh reset.
    pb[0] = 0; pb[1] = 0;
    mode = 1;
    n = 0;
    while ((pb[0] < 18 || pb[1] < 18) && n < 200) begin
      cycle();
      n++;
    end
    chk("phase36_completed", 32'(n < 200), 32'd1);
`ifdef LBP_ARB_STATS_EN
    chk("phase36_stat0", 32'(stat0), 32'd18);
    chk("phase36_stat1", 32'(stat1), 32'd18);
    chk("phase36_stat_sw", 32'(stat_sw), 32'd3);
`endif

    mode = 0;
    repeat (3000) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
